// File: rtl/word_deserializer.sv
// Serial-to-parallel word assembler: 16 bits per word, first received bit lands in out_data[0].
// Optional even-parity trailer bit enabled by defining PARITY_CHECK_EN.
module word_deserializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ser_valid,
  input  logic        ser_data,
  input  logic        ser_start,
  output logic        ser_ready,
  output logic [0:15] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        frame_err
);

  // Handshakes: a bit moves when ser_valid && ser_ready; a word moves when out_valid && out_ready.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef PARITY_CHECK_EN
    HOLD   = 2'd2,
    PARITY = 2'd3
`else
    HOLD   = 2'd2
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [0:15] shift_q, shift_d;
  logic [0:15] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        frame_err_q, frame_err_d;
  logic        accept;
  logic        word_done;

  assign ser_ready = (state_q != HOLD);
  assign accept    = ser_valid && ser_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q && !out_ready;
    frame_err_d = 1'b0;
    word_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ser_start) begin
            shift_d[0] = ser_data;
            cnt_d      = 4'd1;
            state_d    = SHIFT;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (accept) begin
          if (ser_start) begin
            shift_d[0]  = ser_data;
            cnt_d       = 4'd1;
            frame_err_d = 1'b1;
          end else begin
            shift_d[cnt_q] = ser_data;
            cnt_d          = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
`ifdef PARITY_CHECK_EN
              state_d = PARITY;
`else
              word_done = 1'b1;
`endif
            end
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (accept) begin
          if (ser_start) begin
            shift_d[0]  = ser_data;
            cnt_d       = 4'd1;
            frame_err_d = 1'b1;
            state_d     = SHIFT;
          end else if ((^shift_q) == ser_data) begin
            word_done = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
`endif
      HOLD: begin
        // Held word sits in shift_q until the output register frees up.
        if (out_valid_q && out_ready) begin
          out_data_d  = shift_q;
          out_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (word_done) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = shift_d;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end else begin
        state_d = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule
